mem_responder: RTL and testbench
================================

# mem_responder

Multicycle memory responder serving the datapath's single unified memory port (instruction fetch and load/store share it via IorD). It accepts level-held `mem_read`/`mem_write` requests from the multicycle control FSM, models a fixed access latency, commits writes, returns read data in a held output register, and signals completion with a one-cycle `mem_ready` pulse that the control FSM uses to leave its fetch and memory states.

## Interface
- `MEM_DEPTH`, 16384: number of 32-bit words; power of two.
- `LATENCY`, 2: cycles from request acceptance to `mem_ready`; legal range 1..15.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `addr`  input  32  byte address from the IorD mux; sampled on acceptance only.
- `din`  input  32  write data (B register); sampled on acceptance only.
- `mem_read`  input  1  read request, held high by the requester until `mem_ready`.
- `mem_write`  input  1  write request, held high by the requester until `mem_ready`.
- `dout`  output  32  read data register; updated only when a read completes, then held.
- `mem_ready`  output  1  registered one-cycle completion pulse.
- `busy`  output  1  high whenever state is not IDLE.
- `req_err`  output  1  sticky; set when `mem_read` and `mem_write` are both high at acceptance.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: if `mem_read | mem_write` at a rising edge, latch `addr`, `din`, op (write if `mem_write`, else read), load counter with `LATENCY-1`, go to WAIT. Otherwise stay.
- WAIT: counter decrements each edge; on the edge where counter == 0: perform access, assert `mem_ready`, go to RESP.
- RESP: `mem_ready` high for this cycle only; next edge returns to IDLE unconditionally. Requests present in WAIT or RESP are ignored (no re-acceptance of a still-held request).
- Access: word index = `addr[31:2]` modulo `MEM_DEPTH` (upper bits discarded, address wraps). `addr[1:0]` ignored; full-word accesses only.
- Write: array[index] <= latched `din`; `dout` unchanged.
- Read: `dout` <= array[index].
- Both requests high at acceptance: treated as write; `req_err` set and held until reset.
- Counter width: 4 bits.
- Array contents are not reset; initial image loaded by testbench via `$readmemh`.

## Timing
- Reset (edge with `reset`=1): state IDLE, `dout`=0, `mem_ready`=0, `busy`=0, `req_err`=0, counter 0. Reset has priority over every transition.
- Reset during WAIT: pending access aborted; a pending write is never committed.
- Request accepted at edge E0; access performed and `mem_ready` rises at edge E_LATENCY; `mem_ready` falls at E_LATENCY+1 (back to IDLE); earliest next acceptance at E_LATENCY+2.
- `dout` valid from E_LATENCY and stable until the next read completion.
- Throughput: one access per LATENCY+2 cycles.
- `busy` high from E0 through E_LATENCY+1 (exclusive of the IDLE cycle).
- Inputs sampled only at the acceptance edge; changes to `addr`/`din` afterwards have no effect.

## Test plan
- Reset: assert `reset` 2 cycles with `mem_read`=1 -> `dout`=0, `mem_ready`=0, `busy`=0, `req_err`=0; no acceptance while reset high.
- Write/read, LATENCY=2: write `din`=0xDEADBEEF to `addr`=0x10 at E0 -> `mem_ready` high only in cycle after E2; then read 0x10 -> `dout`=0xDEADBEEF at read's E2, `dout` held after `mem_read` drops.
- Held request: keep `mem_read`=1 through `mem_ready` and one extra cycle -> exactly one completion per LATENCY+2 cycles, no back-to-back pulses.
- Wrap/alignment: MEM_DEPTH=16, write 0x11111111 to `addr`=0x43 -> read `addr`=0x00 returns 0x11111111.
- Simultaneous request: `mem_read`=`mem_write`=1, `din`=0xA5A5A5A5, `addr`=0x8 -> write committed, `dout` unchanged, `req_err`=1 until reset.
- Reset mid-write: write 0x12345678 to 0x20 (prior content 0x0), assert `reset` at E1 -> `mem_ready` never pulses; subsequent read of 0x20 returns 0x0.

Source files
------------

// File: rtl/mem_responder.sv
// Multicycle unified-memory responder: accepts one held read/write request,
// waits LATENCY cycles, performs the word access and pulses mem_ready once.
module mem_responder #(
  parameter int MEM_DEPTH = 16384,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] dout,
  output logic        mem_ready,
  output logic        busy,
  output logic        req_err
);

  localparam int             IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [3:0]     CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               wr_q, wr_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic [31:0]        dout_q;
  logic               do_wr, do_rd;

  logic [31:0] mem [MEM_DEPTH];

  // Address bits above the array size wrap away; byte offset is ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:IDX_W+2], addr[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    ready_d = 1'b0;
    err_d   = err_q;
    do_wr   = 1'b0;
    do_rd   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read | mem_write) begin
          idx_d   = addr[IDX_W+1:2];
          wdata_d = din;
          wr_d    = mem_write;
          cnt_d   = CNT_LOAD;
          err_d   = err_q | (mem_read & mem_write);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          // Reset on the completion edge must still suppress the commit.
          do_wr   = wr_q & ~reset;
          do_rd   = ~wr_q;
          ready_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      if (do_rd) dout_q <= mem[idx_q];
    end
  end

  // Latched request fields are only consumed after acceptance, so no reset.
  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    wr_q    <= wr_d;
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[idx_q] <= wdata_q;
  end

  assign dout      = dout_q;
  assign mem_ready = ready_q;
  assign busy      = (state_q != IDLE);
  assign req_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (MEM_DEPTH=16, LATENCY=2).
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] din = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] dout;
  logic        mem_ready;
  logic        busy;
  logic        req_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_responder #(.MEM_DEPTH(16), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .addr(addr), .din(din),
    .mem_read(mem_read), .mem_write(mem_write),
    .dout(dout), .mem_ready(mem_ready), .busy(busy), .req_err(req_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds a request until mem_ready is seen; cyc = edges until the pulse, -1 on timeout.
  task automatic run_op(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, output int cyc);
    addr = a; din = d; mem_write = wr; mem_read = rd; cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (mem_ready) begin cyc = i; break; end
    end
    mem_write = 1'b0; mem_read = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_read = 1'b1; addr = 32'h10;
    tick(); tick();
    n_checks++; if (dout !== 32'd0) begin n_fail++; $display("FAIL rst_dout: got %h want 0", dout); end
    n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", mem_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (req_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", req_err); end
    reset = 1'b0; mem_read = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_no_accept: busy %b want 0", busy); end
  endtask

  task automatic test_write_read();
    int cyc;
    run_op(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, cyc);
    n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL wr_latency: got %0d want 3", cyc); end
    n_checks++; if (dout !== 32'd0) begin n_fail++; $display("FAIL wr_dout_hold: got %h want 0", dout); end
    tick();
    n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL wr_pulse_len: got %b want 0", mem_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_idle: busy %b want 0", busy); end
    run_op(1'b0, 1'b1, 32'h10, 32'h0, cyc);
    n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL rd_latency: got %0d want 3", cyc); end
    n_checks++; if (dout !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", dout); end
    tick(); tick();
    n_checks++; if (dout !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_held: got %h want deadbeef", dout); end
    n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL rd_ready_low: got %b want 0", mem_ready); end
  endtask

  task automatic test_held();
    logic exp_rdy, exp_busy;
    mem_read = 1'b1; addr = 32'h10;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_rdy  = ((k % 4) == 3);
      exp_busy = ((k % 4) != 0);
      n_checks++; if (mem_ready !== exp_rdy) begin n_fail++; $display("FAIL held_ready[%0d]: got %b want %b", k, mem_ready, exp_rdy); end
      n_checks++; if (busy !== exp_busy) begin n_fail++; $display("FAIL held_busy[%0d]: got %b want %b", k, busy, exp_busy); end
    end
    mem_read = 1'b0;
    n_checks++; if (dout !== 32'hDEADBEEF) begin n_fail++; $display("FAIL held_dout: got %h want deadbeef", dout); end
  endtask

  task automatic test_wrap();
    int cyc;
    run_op(1'b1, 1'b0, 32'h43, 32'h11111111, cyc); tick();
    run_op(1'b0, 1'b1, 32'h00, 32'h0, cyc);
    n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL wrap_latency: got %0d want 3", cyc); end
    n_checks++; if (dout !== 32'h11111111) begin n_fail++; $display("FAIL wrap_data: got %h want 11111111", dout); end
    tick();
    run_op(1'b0, 1'b1, 32'h10, 32'h0, cyc);
    n_checks++; if (dout !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wrap_other: got %h want deadbeef", dout); end
    tick();
  endtask

  task automatic test_simul();
    int cyc;
    run_op(1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, cyc);
    n_checks++; if (dout !== 32'hDEADBEEF) begin n_fail++; $display("FAIL both_dout: got %h want deadbeef", dout); end
    n_checks++; if (req_err !== 1'b1) begin n_fail++; $display("FAIL both_err: got %b want 1", req_err); end
    tick();
    run_op(1'b0, 1'b1, 32'h8, 32'h0, cyc);
    n_checks++; if (dout !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL both_commit: got %h want a5a5a5a5", dout); end
    n_checks++; if (req_err !== 1'b1) begin n_fail++; $display("FAIL both_sticky: got %b want 1", req_err); end
    tick();
  endtask

  task automatic test_sample_once();
    int cyc;
    cyc = -1;
    mem_write = 1'b1; addr = 32'h30; din = 32'h55AA55AA;
    tick();
    addr = 32'h34; din = 32'hFFFFFFFF;
    for (int i = 2; i <= 20; i++) begin
      tick();
      if (mem_ready) begin cyc = i; break; end
    end
    mem_write = 1'b0;
    n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL once_latency: got %0d want 3", cyc); end
    tick();
    run_op(1'b0, 1'b1, 32'h30, 32'h0, cyc);
    n_checks++; if (dout !== 32'h55AA55AA) begin n_fail++; $display("FAIL once_data: got %h want 55aa55aa", dout); end
    n_checks++; if (req_err !== 1'b1) begin n_fail++; $display("FAIL once_err_sticky: got %b want 1", req_err); end
    tick();
  endtask

  task automatic test_reset_mid_write();
    int cyc;
    int seen;
    run_op(1'b1, 1'b0, 32'h20, 32'h0, cyc); tick();
    mem_write = 1'b1; addr = 32'h20; din = 32'h12345678;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; mem_write = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_checks++; if (req_err !== 1'b0) begin n_fail++; $display("FAIL mid_err_clr: got %b want 0", req_err); end
    n_checks++; if (dout !== 32'd0) begin n_fail++; $display("FAIL mid_dout: got %h want 0", dout); end
    seen = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (mem_ready) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL mid_no_pulse: got %0d pulses want 0", seen); end
    run_op(1'b0, 1'b1, 32'h20, 32'h0, cyc);
    n_checks++; if (dout !== 32'h0) begin n_fail++; $display("FAIL mid_not_written: got %h want 0", dout); end
    tick();
    // Reset landing exactly on the completion edge.
    run_op(1'b1, 1'b0, 32'h24, 32'hCAFEF00D, cyc); tick();
    mem_write = 1'b1; addr = 32'h24; din = 32'h12345678;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; mem_write = 1'b0;
    n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL e2_ready: got %b want 0", mem_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL e2_busy: got %b want 0", busy); end
    tick();
    run_op(1'b0, 1'b1, 32'h24, 32'h0, cyc);
    n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL e2_rd_latency: got %0d want 3", cyc); end
    n_checks++; if (dout !== 32'hCAFEF00D) begin n_fail++; $display("FAIL e2_not_written: got %h want cafef00d", dout); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_held();
    test_wrap();
    test_simul();
    test_sample_once();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
